display_write_sequencer: RTL and testbench

Owns the write side of the double-buffered display memory. It arbitrates between the graphics engine's pixel writes and its own clear engine, and sequences the buffer-switch request. After each switch it clears the new back buffer. It sits between the graphics command path and the display buffer block, driving that block's pixel write strobe, address and data and its switch-buffer input.

---
 rtl/display_write_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_display_write_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_write_sequencer.sv
// display_write_sequencer
// Write-side owner of the double-buffered display memory: arbitrates
// requester pixel writes against the post-switch clear engine, paces all
// write strobes by WRITE_SPACING, and sequences the buffer-switch pulse.
// Optional feature macro: CLEAR_ON_SWITCH_EN (clear the new back buffer
// after every switch). Without it, WAIT_FRAME returns straight to IDLE.
module display_write_sequencer #(
  parameter int WRITE_SPACING = 2,
  parameter int PIXEL_COUNT   = 256000
) (
  input  logic        clock_in,
  input  logic        reset_in,
  input  logic        req_valid_in,
  input  logic [17:0] req_address_in,
  input  logic [3:0]  req_data_in,
  output logic        req_ready_out,
  input  logic        show_in,
  input  logic [3:0]  clear_color_in,
  input  logic        frame_start_in,
  output logic        pixel_write_enable_out,
  output logic [17:0] pixel_write_address_out,
  output logic [3:0]  pixel_write_data_out,
  output logic        switch_write_buffer_out,
  output logic        busy_out
);

  localparam logic [18:0] ADDR_LIMIT   = 19'(PIXEL_COUNT);
  localparam logic [1:0]  SPACING_LOAD = 2'(WRITE_SPACING - 1);
  localparam logic [1:0]  SWITCH_LAST  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SWITCH     = 2'd1,
`ifdef CLEAR_ON_SWITCH_EN
    ST_WAIT_FRAME = 2'd2,
    ST_CLEAR      = 2'd3
`else
    ST_WAIT_FRAME = 2'd2
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  switch_cnt_q, switch_cnt_d;
  logic [1:0]  spacing_q, spacing_d;
  logic        we_q, we_d;
  logic [17:0] addr_q, addr_d;
  logic [3:0]  data_q, data_d;
  logic        req_accept;
  logic        req_in_range;

`ifdef CLEAR_ON_SWITCH_EN
  localparam logic [17:0] LAST_ADDR = 18'(PIXEL_COUNT - 1);
  logic [17:0] clear_cnt_q, clear_cnt_d;
  logic        clear_last_q, clear_last_d;
  logic [3:0]  color_q, color_d;
`else
  logic        unused_clear_color;
  assign unused_clear_color = ^clear_color_in;
`endif

  // Requester handshake: only in IDLE, yields to show_in and to write pacing.
  always_comb begin
    req_ready_out = (state_q == ST_IDLE) && !show_in &&
                    (spacing_q == '0) && !reset_in;
    req_accept    = req_ready_out && req_valid_in;
    req_in_range  = ({1'b0, req_address_in} < ADDR_LIMIT);
  end

  // Next-state, strobe generation and pacing.
  always_comb begin
    state_d      = state_q;
    switch_cnt_d = switch_cnt_q;
    spacing_d    = (spacing_q != '0) ? spacing_q - 2'd1 : '0;
    we_d         = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
`ifdef CLEAR_ON_SWITCH_EN
    clear_cnt_d  = clear_cnt_q;
    clear_last_d = clear_last_q;
    color_d      = color_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (show_in) begin
          state_d      = ST_SWITCH;
          switch_cnt_d = '0;
`ifdef CLEAR_ON_SWITCH_EN
          color_d      = clear_color_in;
`endif
        end else if (req_accept && req_in_range) begin
          we_d      = 1'b1;
          addr_d    = req_address_in;
          data_d    = req_data_in;
          spacing_d = SPACING_LOAD;
        end
      end

      ST_SWITCH: begin
        if (switch_cnt_q == SWITCH_LAST) begin
          state_d      = ST_WAIT_FRAME;
          switch_cnt_d = '0;
        end else begin
          switch_cnt_d = switch_cnt_q + 2'd1;
        end
      end

      ST_WAIT_FRAME: begin
        if (frame_start_in) begin
`ifdef CLEAR_ON_SWITCH_EN
          state_d      = ST_CLEAR;
          clear_cnt_d  = '0;
          clear_last_d = 1'b0;
`else
          state_d      = ST_IDLE;
`endif
        end
      end

`ifdef CLEAR_ON_SWITCH_EN
      // clear_last_q marks that the final strobe is on the bus this cycle,
      // so IDLE is reached on the cycle after it rather than with it.
      ST_CLEAR: begin
        if (clear_last_q) begin
          state_d = ST_IDLE;
        end else if (spacing_q == '0) begin
          we_d      = 1'b1;
          addr_d    = clear_cnt_q;
          data_d    = color_q;
          spacing_d = SPACING_LOAD;
          if (clear_cnt_q == LAST_ADDR) begin
            clear_last_d = 1'b1;
          end else begin
            clear_cnt_d = clear_cnt_q + 18'd1;
          end
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q      <= ST_IDLE;
      switch_cnt_q <= '0;
      spacing_q    <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
`ifdef CLEAR_ON_SWITCH_EN
      clear_cnt_q  <= '0;
      clear_last_q <= 1'b0;
      color_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      switch_cnt_q <= switch_cnt_d;
      spacing_q    <= spacing_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
`ifdef CLEAR_ON_SWITCH_EN
      clear_cnt_q  <= clear_cnt_d;
      clear_last_q <= clear_last_d;
      color_q      <= color_d;
`endif
    end
  end

  // Output decode: switch pulse covers the first two SWITCH cycles.
  always_comb begin
    pixel_write_enable_out  = we_q;
    pixel_write_address_out = addr_q;
    pixel_write_data_out    = data_q;
    switch_write_buffer_out = (state_q == ST_SWITCH) && (switch_cnt_q != SWITCH_LAST);
    busy_out                = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_display_write_sequencer.sv
// Scoreboard bench for display_write_sequencer. The reference model is a
// timeline: each accepted event schedules the cycles in which strobes,
// the switch pulse and busy must appear; a monitor pops strobes as seen.
module tb_display_write_sequencer;

  localparam int S   = 2;
  localparam int P   = 1200;
  localparam int INF = 32'h7fffffff;

  logic        clk;
  logic        reset_in;
  logic        req_valid_in;
  logic [17:0] req_address_in;
  logic [3:0]  req_data_in;
  logic        req_ready_out;
  logic        show_in;
  logic [3:0]  clear_color_in;
  logic        frame_start_in;
  logic        pixel_write_enable_out;
  logic [17:0] pixel_write_address_out;
  logic [3:0]  pixel_write_data_out;
  logic        switch_write_buffer_out;
  logic        busy_out;

  display_write_sequencer #(.WRITE_SPACING(S), .PIXEL_COUNT(P)) dut (
    .clock_in                (clk),
    .reset_in                (reset_in),
    .req_valid_in            (req_valid_in),
    .req_address_in          (req_address_in),
    .req_data_in             (req_data_in),
    .req_ready_out           (req_ready_out),
    .show_in                 (show_in),
    .clear_color_in          (clear_color_in),
    .frame_start_in          (frame_start_in),
    .pixel_write_enable_out  (pixel_write_enable_out),
    .pixel_write_address_out (pixel_write_address_out),
    .pixel_write_data_out    (pixel_write_data_out),
    .switch_write_buffer_out (switch_write_buffer_out),
    .busy_out                (busy_out)
  );

  typedef struct packed {
    int          cyc;
    logic [17:0] addr;
    logic [3:0]  data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // model timeline
  int       m_active  = 0;
  int       m_from    = 0;
  int       m_idle_at = 0;
  int       m_last    = -100;
  logic [3:0] m_color = '0;
  bit       chk_zero  = 1'b1;
  bit       acc       = 1'b0;
  bit       m_busy    = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, req, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest scheduled one in its cycle.
  always @(negedge clk) begin
    if (cyc > 0) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("strobe_missing_at", exp_q[0].cyc, -1);
        void'(exp_q.pop_front());
      end
      if (pixel_write_enable_out) begin
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          check("strobe_unexpected_addr", int'(pixel_write_address_out), -1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("strobe_addr_data", int'({pixel_write_address_out, pixel_write_data_out}),
                int'({e.addr, e.data}));
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        check("strobe_absent_addr", -1, int'(exp_q[0].addr));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input logic v, input logic [17:0] a, input logic [3:0] d,
                      input logic sh, input logic [3:0] col, input logic fr,
                      input logic rst);
    int  k;
    bit  e_busy, e_sw, e_ready;
    req_valid_in   = v;
    req_address_in = a;
    req_data_in    = d;
    show_in        = sh;
    clear_color_in = col;
    frame_start_in = fr;
    reset_in       = rst;
    @(negedge clk);
    k       = cyc;
    e_busy  = (m_active != 0) && k >= m_from && k < m_idle_at;
    e_sw    = (m_active != 0) && (k == m_from || k == m_from + 1);
    e_ready = !rst && !e_busy && !sh && (k >= m_last + S - 1);
    check("ready", int'(req_ready_out), int'(e_ready));
    check("busy", int'(busy_out), int'(e_busy));
    check("switch", int'(switch_write_buffer_out), int'(e_sw));
    if (chk_zero)
      check("post_reset_outputs", int'({pixel_write_enable_out, pixel_write_address_out,
            pixel_write_data_out, switch_write_buffer_out, busy_out}), 0);
    chk_zero = rst;
    acc = 1'b0;
    if (rst) begin
      m_active = 0;
      m_last   = -100;
      while (exp_q.size() > 0 && exp_q[$].cyc > k) void'(exp_q.pop_back());
    end else if (!e_busy && sh) begin
      m_active  = 1;
      m_from    = k + 1;
      m_idle_at = INF;
      m_color   = col;
    end else if (e_ready && v) begin
      acc = 1'b1;
      if (int'(a) < P) begin
        exp_q.push_back('{cyc: k + 1, addr: a, data: d});
        m_last = k + 1;
      end
    end else if (m_active != 0 && m_idle_at == INF && fr && k >= m_from + 3) begin
`ifdef CLEAR_ON_SWITCH_EN
      for (int j = 0; j < P; j++)
        exp_q.push_back('{cyc: k + 2 + j * S, addr: 18'(j), data: m_color});
      m_last    = k + 2 + (P - 1) * S;
      m_idle_at = m_last + 1;
`else
      m_idle_at = k + 1;
`endif
    end
    m_busy = (m_active != 0) && (k + 1) >= m_from && (k + 1) < m_idle_at;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [17:0] a, input logic [3:0] d);
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) step(1'b1, a, d, 1'b0, '0, 1'b0, 1'b0);
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic run_until_idle();
    for (int i = 0; i < 6000 && m_busy; i++) idle(1);
    if (m_busy) check("idle_timeout", 0, 1);
  endtask

  initial begin
    reset_in = 1'b1; req_valid_in = 1'b0; req_address_in = '0; req_data_in = '0;
    show_in = 1'b0; clear_color_in = '0; frame_start_in = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
    idle(2);

    // single write, then back-to-back stream, then out-of-range address
    send(18'h00005, 4'hA);
    send(18'd10, 4'h1);
    send(18'd11, 4'h2);
    send(18'd12, 4'h3);
    idle(3);
    send(18'(P), 4'h9);
    send(18'd7, 4'h2);
    idle(3);

    // switch and full clear with color 3
    step(1'b0, '0, '0, 1'b1, 4'h3, 1'b0, 1'b0);
    idle(9);
    step(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    run_until_idle();
    idle(3);

    // frame_start during SWITCH is ignored; request with show loses
    step(1'b1, 18'd20, 4'h5, 1'b1, 4'hC, 1'b0, 1'b0);
    idle(1);
    step(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    idle(5);
    step(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    run_until_idle();
    idle(2);

    // request accepted the cycle before show still strobes
    send(18'd33, 4'h6);
    step(1'b0, '0, '0, 1'b1, 4'h7, 1'b0, 1'b0);
    idle(4);
    step(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    run_until_idle();

    // reset when the clear reaches address 1000, then a full restart
    step(1'b0, '0, '0, 1'b1, 4'h5, 1'b0, 1'b0);
    idle(4);
    step(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    idle(1 + 1000 * S);
    step(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
    idle(2);
    step(1'b0, '0, '0, 1'b1, 4'hE, 1'b0, 1'b0);
    idle(4);
    step(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    run_until_idle();

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      logic [17:0] a;
      a = ($urandom % 8 == 0) ? 18'(P + int'($urandom % 16)) : 18'($urandom % P);
      step(1'($urandom % 2), a, 4'($urandom), 1'($urandom % 300 == 0), 4'($urandom),
           1'($urandom % 30 == 0), 1'($urandom % 1500 == 0));
    end
    step(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    run_until_idle();
    idle(4);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
